// File: rtl/aes_vector_sequencer_if.sv
// aes_vector_sequencer_if
// Groups the control, AES-core and readback signals of the AES vector
// sequencer into a single bundle.
//   master : the sequencer itself (drives core enable/plaintext/key,
//            readback window and status).
//   slave  : the environment (drives start/s/sweep, core result and the
//            readback index/slice).
// Signals:
//   start, s, sweep          run control (sampled only while idle)
//   aes_enable               core enable
//   aes_plaintext, aes_key   core inputs
//   aes_cypher               core result
//   rd_idx, rd_slice         readback entry / window select
//   cypher_out               registered readback window
//   busy, done, vec_count    status
interface aes_vector_sequencer_if #(
  parameter int NUM_VEC = 4,
  parameter int OUT_W   = 16
);
  localparam int NSL   = 128 / OUT_W;
  localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int SL_W  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int VC_W  = $clog2(NUM_VEC + 1);

  logic               start;
  logic               s;
  logic               sweep;
  logic               aes_enable;
  logic [127:0]       aes_plaintext;
  logic [127:0]       aes_key;
  logic [127:0]       aes_cypher;
  logic [IDX_W-1:0]   rd_idx;
  logic [SL_W-1:0]    rd_slice;
  logic [OUT_W-1:0]   cypher_out;
  logic               busy;
  logic               done;
  logic [VC_W-1:0]    vec_count;

  modport master (
    input  start, s, sweep, aes_cypher, rd_idx, rd_slice,
    output aes_enable, aes_plaintext, aes_key, cypher_out, busy, done, vec_count
  );

  modport slave (
    output start, s, sweep, aes_cypher, rd_idx, rd_slice,
    input  aes_enable, aes_plaintext, aes_key, cypher_out, busy, done, vec_count
  );
endinterface

// File: rtl/aes_vector_sequencer.sv
// aes_vector_sequencer
// Feeds a fixed AES core with a sequence of plaintexts (base + index),
// waits the core latency for each, and stores every result in a small
// buffer that can be read back one OUT_W-bit window at a time.
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    aes_vector_sequencer_if.master (control, core, readback, status)
module aes_vector_sequencer #(
  parameter int           NUM_VEC     = 4,
  parameter int           OUT_W       = 16,
  parameter int           AES_LATENCY = 11,
  parameter logic [127:0] BASE_PT     = 128'h0123456789abcdeffedcba9876543210,
  parameter logic [127:0] ALT_PT      = 128'h1123456789abcdeffedcba9876543210,
  parameter logic [127:0] KEY         = 128'h0f1571c947d9e8590cb7add6af7f6798
) (
  input logic                    clk,
  input logic                    reset,
  aes_vector_sequencer_if.master bus
);

  localparam int NSL   = 128 / OUT_W;
  localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int VC_W  = $clog2(NUM_VEC + 1);
  localparam int CNT_W = (AES_LATENCY > 1) ? $clog2(AES_LATENCY) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(AES_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VC_W-1:0]    vc_q, vc_d;
  logic               sel_q, sel_d;
  logic               sweep_q, sweep_d;
  logic [127:0]       pt_q, pt_d;
  logic               en_q;
  logic               busy_q;
  logic               done_q;
  logic [OUT_W-1:0]   cout_q;
  logic [127:0]       res_q [NUM_VEC];

  logic               wr_en_s;
  logic [127:0]       base_s;
  logic [127:0]       word_s;
  logic [OUT_W-1:0]   rd_win_s;

  // Next-state, run bookkeeping and capture strobe.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vc_d    = vc_q;
    sel_d   = sel_q;
    sweep_d = sweep_q;
    wr_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sel_d   = bus.s;
          sweep_d = bus.sweep;
          idx_d   = '0;
          vc_d    = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // Counter starts at 0 in the first RUN cycle, so RUN lasts
        // exactly AES_LATENCY cycles.
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = RUN;
        end
      end
      CAPTURE: begin
        wr_en_s = 1'b1;
        vc_d    = vc_q + VC_W'(1);
        if (sweep_q && (int'(idx_q) < NUM_VEC - 1)) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LOAD;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Plaintext for the vector about to be loaded; held stable otherwise.
  always_comb begin
    base_s = sel_d ? ALT_PT : BASE_PT;
    if (state_d == LOAD) begin
      pt_d = base_s + 128'(idx_d);
    end else begin
      pt_d = pt_q;
    end
  end

  // FSM, datapath and status registers. Status flops take their value
  // from the next state so they line up cycle-for-cycle with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vc_q    <= '0;
      sel_q   <= 1'b0;
      sweep_q <= 1'b0;
      pt_q    <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vc_q    <= vc_d;
      sel_q   <= sel_d;
      sweep_q <= sweep_d;
      pt_q    <= pt_d;
      en_q    <= (state_d == RUN);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  // Result buffer; survives across runs and is cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NUM_VEC; j++) begin
        res_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_VEC; j++) begin
        if (wr_en_s && (j == int'(idx_q))) begin
          res_q[j] <= bus.aes_cypher;
        end
      end
    end
  end

  // Readback window select; out-of-range index or slice reads as zero.
  always_comb begin
    word_s   = '0;
    rd_win_s = '0;
    for (int j = 0; j < NUM_VEC; j++) begin
      word_s = (j == int'(bus.rd_idx)) ? res_q[j] : word_s;
    end
    for (int k = 0; k < NSL; k++) begin
      rd_win_s = (k == int'(bus.rd_slice)) ? word_s[k*OUT_W +: OUT_W] : rd_win_s;
    end
  end

  // Registered readback; a same-cycle capture is not visible until the
  // following read, so the old entry contents are returned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cout_q <= '0;
    end else begin
      cout_q <= rd_win_s;
    end
  end

  assign bus.aes_enable    = en_q;
  assign bus.aes_plaintext = pt_q;
  assign bus.aes_key       = KEY;
  assign bus.cypher_out    = cout_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.vec_count     = vc_q;

endmodule

// File: tb/tb_aes_vector_sequencer.sv
// tb_aes_vector_sequencer
// Randomised bench for aes_vector_sequencer with a behavioural core
// (plaintext XOR key after AES_LATENCY enabled cycles) and a buffer model
// derived from the run rules: entry i of a run = (base + i) ^ KEY.
module tb_aes_vector_sequencer;

  localparam int           NUM_VEC = 4;
  localparam int           OUT_W   = 16;
  localparam int           L       = 11;
  localparam logic [127:0] BASE_PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] ALT_PT  = 128'h1123456789abcdeffedcba9876543210;
  localparam logic [127:0] KEY     = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] K3      = 128'hfeedfacecafebabe0badf00da5a55a5a;
  localparam int           NSL     = 128 / OUT_W;
  localparam int           IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int           SL_W    = (NSL > 1) ? $clog2(NSL) : 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes_vector_sequencer_if #(.NUM_VEC(NUM_VEC), .OUT_W(OUT_W)) bus ();
  aes_vector_sequencer #(
    .NUM_VEC(NUM_VEC), .OUT_W(OUT_W), .AES_LATENCY(L),
    .BASE_PT(BASE_PT), .ALT_PT(ALT_PT), .KEY(KEY)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  // Small 3-entry instance used to exercise an out-of-range read index.
  aes_vector_sequencer_if #(.NUM_VEC(3), .OUT_W(OUT_W)) b3 ();
  aes_vector_sequencer #(.NUM_VEC(3), .OUT_W(OUT_W), .AES_LATENCY(2)) dut3 (
    .clk(clk), .reset(reset), .bus(b3));
  assign b3.aes_cypher = K3;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] mbuf [NUM_VEC];

  // Behavioural AES core: result appears after L consecutive enabled cycles,
  // garbage while still computing.
  int ecnt;
  logic [127:0] cy;
  always @(negedge clk) begin
    if (!reset) begin
      ecnt = 0;
      cy   = '0;
    end else if (bus.aes_enable) begin
      ecnt++;
      if (ecnt == L) cy = bus.aes_plaintext ^ KEY;
      else           cy = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      ecnt = 0;
    end
  end
  assign bus.aes_cypher = cy;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_key"}, bus.aes_key, KEY);
    chk({tag, "_cout"}, bus.cypher_out, 0);
    chk({tag, "_vcnt"}, bus.vec_count, 0);
    chk({tag, "_en"}, bus.aes_enable, 0);
    chk({tag, "_pt"}, bus.aes_plaintext, 0);
  endtask

  // Reads every window of every entry; also checks that a change of
  // index/slice is not visible before the next clock edge.
  task automatic readback_all();
    logic [127:0] prev;
    logic [127:0] w;
    prev = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      for (int k = 0; k < NSL; k++) begin
        bus.rd_idx   = IDX_W'(i);
        bus.rd_slice = SL_W'(k);
        if (i != 0 || k != 0) begin
          #1;
          chk("rd_hold", bus.cypher_out, prev);
        end
        @(negedge clk);
        w = mbuf[i];
        prev = 128'(w[k*OUT_W +: OUT_W]);
        chk($sformatf("rd[%0d][%0d]", i, k), bus.cypher_out, prev);
      end
    end
  endtask

  task automatic do_run(input bit s_v, input bit sw_v, input int abort_cyc, input bit poke);
    int n, exp_done, first_done, done_cnt, en_cnt, busy_bad;
    logic [127:0] base, old0, new0;
    n          = sw_v ? NUM_VEC : 1;
    exp_done   = L + 3 + (n - 1) * (L + 2);
    base       = s_v ? ALT_PT : BASE_PT;
    old0       = mbuf[0];
    new0       = base ^ KEY;
    first_done = 0;
    done_cnt   = 0;
    en_cnt     = 0;
    busy_bad   = 0;
    bus.rd_idx   = '0;
    bus.rd_slice = SL_W'(NSL - 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.s     = s_v;
    bus.sweep = sw_v;
    for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
      @(negedge clk);
      if (abort_cyc == cyc) begin
        reset     = 1'b0;
        bus.start = 1'b0;
        break;
      end
      if (poke && cyc < exp_done) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.s     = ~s_v;
        bus.sweep = ~sw_v;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        if (first_done == 0) first_done = cyc;
      end
      if (bus.aes_enable) en_cnt++;
      if (bus.busy !== (cyc <= exp_done)) busy_bad++;
      if (cyc == 2) chk("aes_key", bus.aes_key, KEY);
      if (cyc == L + 3) chk("rd_old_on_write", bus.cypher_out, 128'(old0[128-OUT_W +: OUT_W]));
      if (cyc == L + 4) chk("rd_new_after_write", bus.cypher_out, 128'(new0[128-OUT_W +: OUT_W]));
    end
    if (abort_cyc != 0) begin
      chk("abort_no_done", done_cnt, 0);
      #1;
      reset_chk("abort");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < NUM_VEC; i++) mbuf[i] = '0;
      @(negedge clk);
      chk("post_abort_busy", bus.busy, 0);
    end else begin
      chk("done_cycle", first_done, exp_done);
      chk("done_pulses", done_cnt, 1);
      chk("enable_cycles", en_cnt, n * L);
      chk("busy_profile", busy_bad, 0);
      chk("vec_count", bus.vec_count, n);
      for (int i = 0; i < n; i++) mbuf[i] = (base + 128'(i)) ^ KEY;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ab, ed, w3;
    bit rs, rsw;
    logic [127:0] k3v;
    bus.start = 1'b0; bus.s = 1'b0; bus.sweep = 1'b0;
    bus.rd_idx = '0; bus.rd_slice = '0;
    b3.start = 1'b0; b3.s = 1'b0; b3.sweep = 1'b0;
    b3.rd_idx = '0; b3.rd_slice = '0;
    for (int i = 0; i < NUM_VEC; i++) mbuf[i] = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset_chk("in_reset");
    reset = 1'b1;
    @(negedge clk);
    reset_chk("after_reset");

    // Directed scenarios.
    do_run(1'b0, 1'b0, 0, 1'b0);
    readback_all();
    do_run(1'b1, 1'b1, 0, 1'b1);
    readback_all();
    do_run(1'b0, 1'b1, 30, 1'b0);
    readback_all();
    do_run(1'b0, 1'b1, 0, 1'b0);
    readback_all();

    // Randomised runs, occasionally aborted by reset.
    repeat (8) begin
      rs  = 1'($urandom_range(0, 1));
      rsw = 1'($urandom_range(0, 1));
      ed  = L + 3 + ((rsw ? NUM_VEC : 1) - 1) * (L + 2);
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, ed - 1)) : 0;
      do_run(rs, rsw, ab, 1'($urandom_range(0, 1)));
      readback_all();
    end

    // Out-of-range read index on the 3-entry instance.
    b3.sweep = 1'b1;
    b3.start = 1'b1;
    @(negedge clk);
    b3.start = 1'b0;
    w3 = 0;
    while (!b3.done && w3 < 100) begin
      @(negedge clk);
      w3++;
    end
    chk("n3_done_seen", b3.done, 1);
    chk("n3_vec_count", b3.vec_count, 3);
    k3v = K3;
    b3.rd_idx = 2'd2; b3.rd_slice = '0;
    @(negedge clk);
    chk("n3_last_entry", b3.cypher_out, 128'(k3v[OUT_W-1:0]));
    b3.rd_idx = 2'd3; b3.rd_slice = SL_W'(NSL - 1);
    @(negedge clk);
    chk("n3_idx_out_of_range", b3.cypher_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
